// File: rtl/rx_deser_pkg.sv
// Shared definitions for the RX deserializer: FSM state encoding and the
// default K28.5 alignment symbol.
package rx_deser_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } deser_state_e;

    localparam logic [7:0] K28_5 = 8'hBC;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Asserting clr together with
// inc loads 1, which lets callers restart a count on the event that begins it.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= inc ? W'(1) : '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/rx_deserializer.sv
// Serial-to-byte deserializer with K28.5 comma alignment and lock tracking.
// Optional lock-loss counter output rx_LossCnt enabled by RX_DESER_LOSS_CNT_EN.
module rx_deserializer
    import rx_deser_pkg::*;
#(
    parameter logic [7:0] COMMA      = K28_5,
    parameter int         LOCK_COUNT = 4,
    parameter int         LOSS_COUNT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enb,
    input  logic         rx_SerialE,
    output logic [7:0]   rx_DataE,
    output logic         rx_ByteValid,
    output logic         rx_Locked,
    output deser_state_e dbg_state
`ifdef RX_DESER_LOSS_CNT_EN
    ,
    output logic [7:0]   rx_LossCnt
`endif
);

    localparam int CW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int MW = (LOSS_COUNT < 1) ? 1 : $clog2(LOSS_COUNT + 1);

    deser_state_e r_state;
    deser_state_e w_next_state;
    logic [7:0]   r_sr;
    logic [2:0]   r_bit_cnt;
    logic [7:0]   r_data;
    logic         r_valid;
    logic [CW-1:0] w_comma_cnt;
    logic [MW-1:0] w_miss_cnt;

    logic [7:0] w_window;
    logic       w_is_comma;
    logic       w_boundary;
    logic       w_bit_clr;
    logic       w_comma_inc;
    logic       w_comma_clr;
    logic       w_miss_inc;
    logic       w_miss_clr;
    logic       w_emit;

    assign w_window   = {r_sr[6:0], rx_SerialE};
    assign w_is_comma = (w_window == COMMA);
    assign w_boundary = (r_bit_cnt == 3'd7);

    // Next-state and counter controls; nothing moves on a disabled cycle.
    always_comb begin
        w_next_state = r_state;
        w_bit_clr    = 1'b0;
        w_comma_inc  = 1'b0;
        w_comma_clr  = 1'b0;
        w_miss_inc   = 1'b0;
        w_miss_clr   = 1'b0;
        w_emit       = 1'b0;
        if (enb) begin
            case (r_state)
                SEARCH: begin
                    if (w_is_comma) begin
                        w_next_state = CHECK;
                        w_bit_clr    = 1'b1;
                        w_comma_clr  = 1'b1;
                        w_comma_inc  = 1'b1;
                    end
                end
                CHECK: begin
                    if (w_boundary) begin
                        if (w_is_comma) begin
                            w_comma_inc = 1'b1;
                            if (w_comma_cnt >= CW'(LOCK_COUNT - 1)) begin
                                w_next_state = LOCKED;
                            end
                        end else begin
                            w_next_state = SEARCH;
                            w_comma_clr  = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (w_boundary) begin
                        w_emit = 1'b1;
                        if (w_is_comma) begin
                            w_miss_clr = 1'b1;
                        end
                    end else if (w_is_comma) begin
                        if (w_miss_cnt >= MW'(LOSS_COUNT - 1)) begin
                            // Re-align on this comma; it counts as the first of the new phase.
                            w_next_state = CHECK;
                            w_bit_clr    = 1'b1;
                            w_comma_clr  = 1'b1;
                            w_comma_inc  = 1'b1;
                            w_miss_clr   = 1'b1;
                        end else begin
                            w_miss_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    w_next_state = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SEARCH;
            r_sr      <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_valid <= w_emit;
            if (w_emit) begin
                r_data <= w_window;
            end
            if (enb) begin
                r_sr <= w_window;
                if (w_bit_clr) begin
                    r_bit_cnt <= 3'd0;
                end else if (r_state != SEARCH) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
        end
    end

    sat_counter #(.W(CW)) u_comma_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_comma_inc),
        .clr (w_comma_clr),
        .q   (w_comma_cnt)
    );

    sat_counter #(.W(MW)) u_miss_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_miss_inc),
        .clr (w_miss_clr),
        .q   (w_miss_cnt)
    );

`ifdef RX_DESER_LOSS_CNT_EN
    logic w_loss;
    assign w_loss = enb && (r_state == LOCKED) && (w_next_state == CHECK);

    sat_counter #(.W(8)) u_loss_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_loss),
        .clr (1'b0),
        .q   (rx_LossCnt)
    );
`endif

    assign rx_DataE     = r_data;
    assign rx_ByteValid = r_valid;
    assign rx_Locked    = (r_state == LOCKED);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_rx_deserializer.sv
// Self-checking bench for rx_deserializer: directed scenarios plus a random
// comma/data/slip stream, all checked against a bit-level behavioural model.
module tb_rx_deserializer;
  import rx_deser_pkg::*;

  localparam logic [7:0] COMMA  = 8'hBC;
  localparam int         LOCK_N = 4;
  localparam int         LOSS_N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         enb;
  logic         rx_SerialE;
  logic [7:0]   rx_DataE;
  logic         rx_ByteValid;
  logic         rx_Locked;
  deser_state_e dbg_state;
`ifdef RX_DESER_LOSS_CNT_EN
  logic [7:0]   rx_LossCnt;
`endif

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rx_deserializer #(
    .COMMA      (COMMA),
    .LOCK_COUNT (LOCK_N),
    .LOSS_COUNT (LOSS_N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb),
    .rx_SerialE   (rx_SerialE),
    .rx_DataE     (rx_DataE),
    .rx_ByteValid (rx_ByteValid),
    .rx_Locked    (rx_Locked),
    .dbg_state    (dbg_state)
`ifdef RX_DESER_LOSS_CNT_EN
    ,
    .rx_LossCnt   (rx_LossCnt)
`endif
  );

  // ---------------- behavioural model ----------------
  // Tracks the last eight bits, how many bits have passed since the current
  // alignment point, and lock status; a byte is due every eighth bit.
  int         m_win, m_since, m_commas, m_misses, m_losses;
  bit         m_aligned, m_locked, m_valid;
  logic [7:0] m_data;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic model_reset();
    m_win = 0; m_since = 0; m_commas = 0; m_misses = 0; m_losses = 0;
    m_aligned = 0; m_locked = 0; m_valid = 0; m_data = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_step(bit en, bit b);
    bit boundary;
    m_valid = 0;
    if (!en) return;
    m_win = ((m_win << 1) | int'(b)) & 255;
    m_since++;
    boundary = m_aligned && (m_since % 8 == 0);
    if (!m_aligned) begin
      if (m_win == int'(COMMA)) begin
        m_aligned = 1; m_since = 0; m_commas = 1;
      end
    end else if (!m_locked) begin
      if (boundary) begin
        if (m_win == int'(COMMA)) begin
          m_commas++;
          if (m_commas >= LOCK_N) m_locked = 1;
        end else begin
          m_aligned = 0; m_commas = 0;
        end
      end
    end else begin
      if (boundary) begin
        m_valid = 1;
        m_data  = m_win[7:0];
        exp_q.push_back(m_data);
        if (m_win == int'(COMMA)) m_misses = 0;
      end else if (m_win == int'(COMMA)) begin
        m_misses++;
        if (m_misses >= LOSS_N) begin
          m_locked = 0; m_since = 0; m_commas = 1; m_misses = 0; m_losses++;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step(enb, rx_SerialE);
  end

  // ---------------- scoreboard ----------------
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("byte_valid", int'(rx_ByteValid), int'(m_valid));
      check("locked", int'(rx_Locked), int'(m_locked));
      if (rx_ByteValid) begin
        got_q.push_back(rx_DataE);
        if (exp_q.size() == 0) check("unexpected_byte", int'(rx_DataE), -1);
        else                   check("byte_data", int'(rx_DataE), int'(exp_q.pop_front()));
      end
      check("data_hold", int'(rx_DataE), int'(m_data));
`ifdef RX_DESER_LOSS_CNT_EN
      check("loss_cnt", int'(rx_LossCnt), (m_losses > 255) ? 255 : m_losses);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(bit en, bit b);
    @(negedge clk);
    enb = en;
    rx_SerialE = b;
  endtask

  task automatic send_byte(logic [7:0] v, bit toggle = 0);
    for (int i = 7; i >= 0; i--) begin
      if (toggle) drive(0, 1'($urandom_range(0, 1)));
      drive(1, v[i]);
    end
  endtask

  task automatic send_bits(logic [31:0] v, int n);
    for (int i = n - 1; i >= 0; i--) drive(1, v[i]);
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 1'($urandom_range(0, 1)));
  endtask

  task automatic settle();
    idle(2);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; enb = 0; rx_SerialE = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    got_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [12:0] pre;
    logic [7:0]  arr[6];
    bit          ok;
    int          w;

    rst = 1; enb = 0; rx_SerialE = 0;
    #3;
    check("rst_data", int'(rx_DataE), 0);
    check("rst_valid", int'(rx_ByteValid), 0);
    check("rst_locked", int'(rx_Locked), 0);
    check("rst_state", int'(dbg_state), int'(SEARCH));
    do_reset();

    // Random prefix that contains no comma of its own, then 5 commas and 1C.
    do begin
      pre = 13'($urandom);
      ok = 1; w = 0;
      for (int i = 12; i >= 0; i--) begin
        w = ((w << 1) | int'(pre[i])) & 255;
        if (w == int'(COMMA)) ok = 0;
      end
    end while (!ok);
    send_bits(32'(pre), 13);
    repeat (4) send_byte(COMMA);
    settle();
    check("t1_locked_after_4", int'(rx_Locked), 1);
    check("t1_no_bytes_yet", got_q.size(), 0);
    send_byte(COMMA);
    send_byte(8'h1C);
    settle();
    check("t1_byte_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t1_first_byte", int'(got_q[0]), 'hBC);
      check("t1_second_byte", int'(got_q[1]), 'h1C);
    end

    // Three commas then a non-comma at the boundary: back to search.
    do_reset();
    repeat (3) send_byte(COMMA);
    send_byte(8'h55);
    send_bits(32'h0, 16);
    settle();
    check("t2_not_locked", int'(rx_Locked), 0);
    check("t2_state_search", int'(dbg_state), int'(SEARCH));
    check("t2_no_bytes", got_q.size(), 0);

    // Lock, then slip by 3 bits and keep sending commas at the new phase.
    do_reset();
    repeat (5) send_byte(COMMA);
    send_byte(8'h5A);
    send_byte(8'h00);
    send_bits(32'h0, 3);
    repeat (2) send_byte(COMMA);
    settle();
    check("t3_still_locked", int'(rx_Locked), 1);
    send_byte(COMMA);
    settle();
    check("t3_lock_lost", int'(rx_Locked), 0);
`ifdef RX_DESER_LOSS_CNT_EN
    check("t3_loss_cnt", int'(rx_LossCnt), 1);
`endif
    repeat (3) send_byte(COMMA);
    settle();
    check("t3_relocked", int'(rx_Locked), 1);
    send_byte(8'hA5);
    settle();
    check("t3_last_byte", (got_q.size() > 0) ? int'(got_q[$]) : -1, 'hA5);

    // Enable toggling every cycle yields the same byte sequence.
    do_reset();
    foreach (arr[i]) arr[i] = 8'($urandom_range(0, 255));
    repeat (5) send_byte(COMMA, 1);
    foreach (arr[i]) send_byte(arr[i], 1);
    settle();
    check("t4_byte_count", got_q.size(), 7);
    if (got_q.size() == 7) begin
      check("t4_first_byte", int'(got_q[0]), 'hBC);
      foreach (arr[i]) check("t4_data_byte", int'(got_q[i + 1]), int'(arr[i]));
    end

    // Asynchronous reset while locked and mid-byte.
    do_reset();
    repeat (5) send_byte(COMMA);
    send_byte(8'h3C);
    send_bits(32'h7, 3);
    @(negedge clk);
    #3 rst = 1;
    #1;
    check("t5_async_data", int'(rx_DataE), 0);
    check("t5_async_valid", int'(rx_ByteValid), 0);
    check("t5_async_locked", int'(rx_Locked), 0);
    check("t5_async_state", int'(dbg_state), int'(SEARCH));
    repeat (2) @(negedge clk);
    rst = 0;
    got_q.delete();
    send_bits(32'h10, 5);
    send_byte(8'h12);
    send_byte(8'h34);
    settle();
    check("t5_no_bytes_after_rst", got_q.size(), 0);
    check("t5_unlocked_after_rst", int'(rx_Locked), 0);
    repeat (5) send_byte(COMMA);
    send_byte(8'h77);
    settle();
    check("t5_relock_bytes", got_q.size(), 2);
    check("t5_relock_last", (got_q.size() > 0) ? int'(got_q[$]) : -1, 'h77);

    // Random stream: mostly commas, some data bytes, occasional bit slips.
    do_reset();
    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        send_byte(COMMA, $urandom_range(0, 3) == 0);
      end else if (r < 8) begin
        send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
      end else begin
        send_bits($urandom, $urandom_range(1, 7));
      end
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    settle();
    check("rand_exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
